// File: rtl/i2c_byte_ctrl_if.sv
// Command/response handshake bundle for i2c_byte_ctrl.
//   cmd_*  : byte-level command (START / WRITE / READ / STOP) with valid/ready
//   rsp_*  : per-command response (read data, write ACK, reject flag) with valid/ready
// master : command issuer / response consumer
// slave  : the byte controller
interface i2c_byte_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       cmd_nack;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_ack;
   logic       rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_nack, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_ack, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_nack, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_ack, rsp_err
   );
endinterface

// File: rtl/i2c_byte_ctrl.sv
// I2C byte-level controller. Turns START / WRITE / READ / STOP commands into
// sequences of single-bit strobes for a bit-level PHY and returns one
// response per command.
//   clk, rst        : clock, synchronous active-high reset
//   bus             : command/response handshake (slave side)
//   abort           : immediate bus release; wins over any handshake
//   busy            : controller not idle
//   phy_*_bit       : one-hot bit strobes to the PHY, phy_tx_data is the bit value
//   phy_release_bus : one-cycle release pulse on abort
//   phy_state       : PHY state, PHY_ST_IDLE / PHY_ST_ACTIVE are its rest states
//   phy_rx_data     : SDA bit sampled by the PHY for the last completed bit
module i2c_byte_ctrl #(
   parameter logic [4:0] PHY_ST_IDLE   = 5'd0,
   parameter logic [4:0] PHY_ST_ACTIVE = 5'd1
) (
   input  logic            clk,
   input  logic            rst,
   i2c_byte_ctrl_if.slave  bus,
   input  logic            abort,
   output logic            busy,
   output logic            phy_start_bit,
   output logic            phy_stop_bit,
   output logic            phy_write_bit,
   output logic            phy_read_bit,
   output logic            phy_tx_data,
   output logic            phy_release_bus,
   input  logic [4:0]      phy_state,
   input  logic            phy_rx_data
);

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_STOP  = 2'b11;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic [1:0] op;
      logic [7:0] data;
      logic       nack;
   } cmd_t;

   state_t     state;
   cmd_t       cmd;
   logic [3:0] cnt;
   logic       owned;
   logic       rep;       // START accepted while the bus was already owned
   logic [7:0] rx;
   logic       abort_q;
   logic [4:0] iss_st;
   logic [4:0] wait_st;
   logic       last_bit;

   // Strobe vector for bit n of an op: {start, stop, write, read, tx}.
   // ~n[2:0] == 7-n for n in 0..7, giving MSB-first transmission.
   function automatic logic [4:0] bit_strobe(input logic [1:0] op, input logic [3:0] n,
                                             input logic [7:0] d, input logic nk);
      logic [4:0] s;
      s = 5'b0;
      case (op)
         OP_START: s = 5'b10000;
         OP_STOP:  s = 5'b01000;
         OP_WRITE: s = n[3] ? 5'b00010 : {4'b0010, d[~n[2:0]]};
         OP_READ:  s = n[3] ? {4'b0010, nk} : 5'b00010;
         default:  s = 5'b0;
      endcase
      return s;
   endfunction

   assign bus.cmd_ready = (state == IDLE) & ~rst;
   assign busy          = (state != IDLE) & ~rst;

   // A fresh START is launched from an idle PHY; everything else rides on a held bus.
   assign iss_st   = (cmd.op == OP_START && !rep) ? PHY_ST_IDLE : PHY_ST_ACTIVE;
   assign wait_st  = (cmd.op == OP_STOP) ? PHY_ST_IDLE : PHY_ST_ACTIVE;
   assign last_bit = (cmd.op == OP_START) || (cmd.op == OP_STOP) || (cnt == 4'd8);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cmd             <= '0;
         cnt             <= 4'd0;
         owned           <= 1'b0;
         rep             <= 1'b0;
         rx              <= 8'd0;
         abort_q         <= 1'b0;
         phy_release_bus <= 1'b0;
         phy_start_bit   <= 1'b0;
         phy_stop_bit    <= 1'b0;
         phy_write_bit   <= 1'b0;
         phy_read_bit    <= 1'b0;
         phy_tx_data     <= 1'b0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_data    <= 8'd0;
         bus.rsp_ack     <= 1'b0;
         bus.rsp_err     <= 1'b0;
      end else begin
         abort_q         <= abort;
         // Edge-detected so a held abort still yields a single release pulse.
         phy_release_bus <= abort & ~abort_q;
         if (abort) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            owned         <= 1'b0;
            {phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_tx_data} <= 5'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 8'd0;
            bus.rsp_ack   <= 1'b0;
            bus.rsp_err   <= 1'b0;
         end else begin
            case (state)
               IDLE: if (bus.cmd_valid) begin
                  cmd <= '{op: bus.cmd_op, data: bus.cmd_data, nack: bus.cmd_nack};
                  cnt <= 4'd0;
                  rep <= owned;
                  rx  <= 8'd0;
                  if (bus.cmd_op != OP_START && !owned) begin
                     state         <= RESP;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_ack   <= 1'b0;
                     bus.rsp_data  <= 8'd0;
                  end else begin
                     state <= ISSUE;
                     {phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_tx_data}
                        <= bit_strobe(bus.cmd_op, 4'd0, bus.cmd_data, bus.cmd_nack);
                  end
               end
               // Strobe stays up until the PHY leaves its rest state, i.e. took the bit.
               ISSUE: if (phy_state != iss_st) begin
                  {phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit} <= 4'b0;
                  state <= WAIT;
               end
               WAIT: if (phy_state == wait_st) begin
                  if (cmd.op == OP_READ && !cnt[3])
                     rx <= {rx[6:0], phy_rx_data};
                  if (last_bit) begin
                     state         <= RESP;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b0;
                     bus.rsp_ack   <= (cmd.op == OP_WRITE) & ~phy_rx_data;
                     bus.rsp_data  <= (cmd.op == OP_READ) ? rx : 8'd0;
                     if (cmd.op == OP_START) owned <= 1'b1;
                     if (cmd.op == OP_STOP)  owned <= 1'b0;
                  end else begin
                     cnt   <= cnt + 4'd1;
                     state <= ISSUE;
                     {phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_tx_data}
                        <= bit_strobe(cmd.op, cnt + 4'd1, cmd.data, cmd.nack);
                  end
               end
               RESP: if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Bench for i2c_byte_ctrl: behavioural PHY + slave model, expected strobe
// streams and responses built from the byte-level protocol rules.
module tb_i2c_byte_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   i2c_byte_ctrl_if bus();

   logic       abort = 1'b0;
   logic       busy;
   logic       ps, pp, pw, pr, ptx, prel;
   logic [4:0] phy_state = 5'd0;
   logic       phy_rx_data = 1'b1;

   i2c_byte_ctrl #(.PHY_ST_IDLE(5'd0), .PHY_ST_ACTIVE(5'd1)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .abort           (abort),
      .busy            (busy),
      .phy_start_bit   (ps),
      .phy_stop_bit    (pp),
      .phy_write_bit   (pw),
      .phy_read_bit    (pr),
      .phy_tx_data     (ptx),
      .phy_release_bus (prel),
      .phy_state       (phy_state),
      .phy_rx_data     (phy_rx_data)
   );

   int checks = 0;
   int failures = 0;

   // Event codes: START=0, STOP=2, WRITE bit=4+value, READ bit=6.
   int log_q[$];
   int exp_q[$];
   bit slave_q[$];
   int strobe_cycles = 0;
   bit excl_bad = 1'b0;
   bit m_owned = 1'b0;

   // Behavioural PHY: takes a strobe only in a rest state, stays busy a random
   // few cycles, then settles (IDLE after STOP) with the slave's SDA bit.
   int pcnt = 0;
   bit pend_stop, pend_read;
   always @(posedge clk) begin
      if (ps | pp | pw | pr) strobe_cycles++;
      if ((32'(ps) + 32'(pp) + 32'(pw) + 32'(pr)) > 1) excl_bad <= 1'b1;
      if (rst || prel) begin
         phy_state <= 5'd0;
         pcnt      = 0;
      end else if (phy_state == 5'd0 || phy_state == 5'd1) begin
         if (ps | pp | pw | pr) begin
            log_q.push_back(ps ? 0 : pp ? 2 : pw ? (4 + int'(ptx)) : 6);
            pend_stop = pp;
            pend_read = pr;
            pcnt      = $urandom_range(4, 1);
            phy_state <= 5'd2;
         end
      end else begin
         if (pcnt > 1) pcnt--;
         else begin
            bit b;
            b = 1'b1;
            if (pend_read && slave_q.size() > 0) b = slave_q.pop_front();
            if (pend_read) phy_rx_data <= b;
            phy_state <= pend_stop ? 5'd0 : 5'd1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Protocol-level expectation for one command.
   task automatic model_cmd(input logic [1:0] op, input logic [7:0] d, input logic n,
                            input logic slv_ack, input logic [7:0] slv_byte,
                            output logic e_err, output logic e_ack, output logic [7:0] e_data);
      exp_q.delete();
      e_err = 1'b0; e_ack = 1'b0; e_data = 8'd0;
      if (op != 2'b00 && !m_owned) e_err = 1'b1;
      else case (op)
         2'b00: begin exp_q.push_back(0); m_owned = 1'b1; end
         2'b11: begin exp_q.push_back(2); m_owned = 1'b0; end
         2'b01: begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(4 + int'(d[i]));
            exp_q.push_back(6);
            slave_q.push_back(~slv_ack);
            e_ack = slv_ack;
         end
         default: begin
            for (int i = 7; i >= 0; i--) begin
               exp_q.push_back(6);
               slave_q.push_back(slv_byte[i]);
            end
            exp_q.push_back(4 + int'(n));
            e_data = slv_byte;
         end
      endcase
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic n);
      int k;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      bus.cmd_nack  = n;
      k = 0;
      while (!bus.cmd_ready && k < 200) begin @(negedge clk); k++; end
      if (k >= 200) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic finish_rsp(input string tag, input logic e_err, input logic e_ack,
                             input logic [7:0] e_data, input int hold);
      int k;
      bit ok;
      @(negedge clk);
      k = 0;
      while (!bus.rsp_valid && k < 2000) begin @(negedge clk); k++; end
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
      chk({tag, "_rsp_err"}, bus.rsp_err, e_err);
      chk({tag, "_rsp_ack"}, bus.rsp_ack, e_ack);
      chk({tag, "_rsp_data"}, bus.rsp_data, e_data);
      ok = (log_q.size() == exp_q.size());
      if (ok) foreach (exp_q[i]) if (log_q[i] != exp_q[i]) ok = 1'b0;
      chk({tag, "_bit_stream"}, ok, 1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, bus.rsp_valid, 1);
         chk({tag, "_hold_data"}, {bus.rsp_err, bus.rsp_ack, bus.rsp_data}, {e_err, e_ack, e_data});
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_rsp_drop"}, bus.rsp_valid, 0);
      chk({tag, "_ready_again"}, bus.cmd_ready, 1);
   endtask

   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] d,
                          input logic n, input logic slv_ack, input logic [7:0] slv_byte,
                          input int hold);
      logic e_err, e_ack;
      logic [7:0] e_data;
      log_q.delete();
      model_cmd(op, d, n, slv_ack, slv_byte, e_err, e_ack, e_data);
      issue(op, d, n);
      finish_rsp(tag, e_err, e_ack, e_data, hold);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, k, seen;
      logic [1:0] op;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = 8'd0;
      bus.cmd_nack  = 1'b0;
      bus.rsp_ready = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_ack, bus.rsp_data}, 0);
      chk("rst_strobes", {ps, pp, pw, pr, ptx, prel}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", bus.cmd_ready, 1);

      // WRITE without owning the bus: reject on the very next cycle, no strobes.
      sc = strobe_cycles;
      log_q.delete();
      exp_q.delete();
      issue(2'b01, 8'h5A, 1'b0);
      @(negedge clk);
      chk("nostart_err_next", {bus.rsp_valid, bus.rsp_err}, 2'b11);
      finish_rsp("nostart", 1'b1, 1'b0, 8'h00, 0);
      chk("nostart_no_strobe", strobe_cycles, sc);

      run_cmd("start", 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      run_cmd("wr_a5", 2'b01, 8'hA5, 1'b0, 1'b1, 8'h00, 0);
      run_cmd("wr_3c_nack", 2'b01, 8'h3C, 1'b0, 1'b0, 8'h00, 0);
      run_cmd("rd_96", 2'b10, 8'h00, 1'b1, 1'b0, 8'h96, 0);
      run_cmd("stop", 2'b11, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      chk("stop_phy_idle", phy_state, 5'd0);
      run_cmd("stop_unowned", 2'b11, 8'h00, 1'b0, 1'b0, 8'h00, 0);

      // Repeated start with response back-pressure.
      run_cmd("start2", 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      run_cmd("rep_start", 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 10);

      // Randomised command stream.
      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom_range(3, 0));
         run_cmd("rand", op, 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 0);
      end
      run_cmd("rand_stop", 2'b11, 8'h00, 1'b0, 1'b0, 8'h00, 0);

      // Abort in the middle of bit 4 of a WRITE.
      run_cmd("start3", 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 0);
      log_q.delete();
      slave_q.delete();
      issue(2'b01, 8'hC3, 1'b0);
      k = 0;
      while (log_q.size() < 5 && k < 500) begin @(negedge clk); k++; end
      chk("abort_reach_bit4", log_q.size(), 5);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_release", prel, 1);
      chk("abort_ready", bus.cmd_ready, 1);
      chk("abort_strobes", {ps, pp, pw, pr}, 0);
      seen = 0;
      @(negedge clk);
      chk("abort_release_1cyc", prel, 0);
      for (int i = 0; i < 20; i++) begin
         if (bus.rsp_valid) seen++;
         @(negedge clk);
      end
      chk("abort_no_rsp", seen, 0);
      m_owned = 1'b0;
      run_cmd("after_abort", 2'b10, 8'h00, 1'b0, 1'b0, 8'h00, 0);

      chk("strobe_exclusive", excl_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_byte_ctrl.md
I2C_BYTE_CTRL -- requirements
Module: i2c_byte_ctrl

Interface
REQ-001 Parameter PHY_ST_IDLE, default 5'd0, PHY idle state encoding.
REQ-002 Parameter PHY_ST_ACTIVE, default 5'd1, PHY bus-held-active state encoding.
REQ-003 clk  in  1  clock; all logic SHALL be on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-007 cmd_op  in  2  00 START, 01 WRITE byte, 10 READ byte, 11 STOP.
REQ-008 cmd_data  in  8  byte to write (WRITE only).
REQ-009 cmd_nack  in  1  READ only: 1 = send NACK after the byte, 0 = send ACK.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
REQ-012 rsp_data  out  8  READ byte received, MSB first; 0 for other ops.
REQ-013 rsp_ack  out  1  WRITE: 1 = slave ACKed (SDA sampled 0); 0 otherwise.
REQ-014 rsp_err  out  1  command rejected, bus not owned.
REQ-015 abort  in  1  immediate bus release request.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit  out  1 each  PHY bit strobes.
REQ-018 phy_tx_data  out  1  bit value for phy_write_bit.
REQ-019 phy_release_bus  out  1  PHY release pulse.
REQ-020 phy_state  in  5  PHY state register.
REQ-021 phy_rx_data  in  1  PHY sampled SDA bit.

Function
REQ-022 Controller FSM SHALL have states IDLE, ISSUE, WAIT, RESP; cmd_ready SHALL equal (state==IDLE)&~rst.
REQ-023 On accept, op/data/nack SHALL be registered, bit counter cleared to 0, FSM to ISSUE (START/STOP/WRITE/READ) or RESP (reject).
REQ-024 Internal flag owned SHALL set when a START completes, clear when a STOP completes or on abort.
REQ-025 WRITE, READ or STOP accepted with owned=0 SHALL go directly to RESP with rsp_err=1, no PHY strobe.
REQ-026 START with owned=1 SHALL issue phy_start_bit (repeated start).
REQ-027 ISSUE: exactly one strobe held high while phy_state equals PHY_ST_ACTIVE (PHY_ST_IDLE for a non-repeated START); first cycle phy_state differs, strobe SHALL drop and FSM go to WAIT.
REQ-028 WAIT: FSM SHALL wait for phy_state==PHY_ST_ACTIVE (PHY_ST_IDLE after STOP), then finish the bit.
REQ-029 WRITE sequence: bits 0-7 phy_write_bit with phy_tx_data=cmd_data[7-n], bit 8 phy_read_bit; on bit 8 completion rsp_ack=~phy_rx_data.
REQ-030 READ sequence: bits 0-7 phy_read_bit, phy_rx_data shifted into LSB on each completion; bit 8 phy_write_bit with phy_tx_data=cmd_nack.
REQ-031 After a bit completes with counter<8 the counter SHALL increment and FSM return to ISSUE; at counter==8 (or after START/STOP single bit) go to RESP.
REQ-032 RESP: rsp_valid high, rsp_* stable until rsp_ready; then FSM to IDLE next cycle, rsp_valid low.
REQ-033 Strobes SHALL be registered, mutually exclusive, low outside ISSUE.
REQ-034 abort in any state SHALL pulse phy_release_bus for exactly one cycle, drop all strobes, clear owned, discard any pending response, FSM to IDLE; abort has priority over simultaneous cmd_valid and rsp_ready.

Reset
REQ-035 Under rst: FSM IDLE, owned=0, counter 0, all strobes/phy_tx_data/phy_release_bus 0, rsp_valid/rsp_data/rsp_ack/rsp_err 0, busy 0, cmd_ready 0.
REQ-036 rst mid-command SHALL abandon it with no response; PHY reset is the responsibility of the shared rst.

Verification (with i2c_phy, prescale=2, open-drain bus model and slave model)
REQ-037 START then WRITE 0xA5, slave ACKs -> SDA bits 1,0,1,0,0,1,0,1 on SCL highs, rsp_ack=1, rsp_err=0.
REQ-038 WRITE 0x3C, no slave -> rsp_ack=0; then STOP -> PHY returns IDLE, owned=0.
REQ-039 READ with slave driving 0x96, cmd_nack=1 -> rsp_data=0x96, ninth SCL pulse SDA high.
REQ-040 WRITE after reset with no START -> rsp_err=1 next cycle, zero strobe activity.
REQ-041 abort during bit 4 of WRITE -> one-cycle phy_release_bus, SCL/SDA released, rsp_valid never asserted, cmd_ready 1 next cycle.
REQ-042 START, START (repeated), hold rsp_ready low 10 cycles -> rsp_valid held, second START drives SDA rise-then-fall with SCL high.
